// File: rtl/hamming_dec_stream.sv
// hamming_dec_stream: two-stage pipelined SECDED Hamming decoder with a
// valid/ready stream on both sides.
// Stage 1 registers the codeword, its syndrome and its overall parity.
// Stage 2 registers the corrected data word and the error flags.
// Optional feature macro HAMMING_ERR_CNT_EN builds saturating counters
// for corrected and uncorrectable errors; without it the counters read 0.
module hamming_dec_stream #(
   parameter  int K     = 8,
   parameter  int CNT_W = 16,
   localparam int M     = $clog2(K + 1 + $clog2(K + 1 + $clog2(K + 1))),
   localparam int N     = M + K
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N:0]       cw_i,
   input  logic             cw_valid_i,
   output logic             cw_ready_o,
   output logic [K-1:0]     q_o,
   output logic [M-1:0]     syndrome_o,
   output logic             sb_err_o,
   output logic             sb_fix_o,
   output logic             db_err_o,
   output logic             q_valid_o,
   input  logic             q_ready_i,
   input  logic             clr_cnt_i,
   output logic [CNT_W-1:0] sb_cnt_o,
   output logic [CNT_W-1:0] db_cnt_o
);

   // Hamming position holding data bit k (positions skip powers of two).
   function automatic int data_pos(input int k);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == k) res = p;
            cnt++;
         end
      end
      return res;
   endfunction

   logic         en;
   logic         s1_valid_q;
   logic [N:0]   s1_cw_q;
   logic [M-1:0] s1_syn_q, s1_syn_d;
   logic         s1_pe_q, s1_pe_d;

   logic         q_valid_q;
   logic [K-1:0] q_q, q_d;
   logic [M-1:0] syn_q;
   logic         sb_q, sb_d;
   logic         db_q, db_d;
   logic [N:0]   fixed;
   logic         flip;

   // Whole pipeline advances together whenever the output slot is free.
   assign en         = !q_valid_q || q_ready_i;
   assign cw_ready_o = en;

   // Syndrome and overall parity of the incoming codeword.
   always_comb begin
      s1_syn_d = '0;
      s1_pe_d  = ^cw_i;
      for (int i = 1; i <= N; i++) begin
         if (cw_i[i]) s1_syn_d = s1_syn_d ^ M'(i);
      end
   end

   // Stage 1 register: codeword, syndrome, parity, valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_cw_q    <= '0;
         s1_syn_q   <= '0;
         s1_pe_q    <= 1'b0;
      end else if (en) begin
         s1_valid_q <= cw_valid_i;
         s1_cw_q    <= cw_i;
         s1_syn_q   <= s1_syn_d;
         s1_pe_q    <= s1_pe_d;
      end
   end

   // Classify the error, flip the addressed position, extract data bits.
   always_comb begin
      sb_d  = 1'b0;
      db_d  = 1'b0;
      flip  = 1'b0;
      fixed = s1_cw_q;
      q_d   = '0;
      if (s1_pe_q) begin
         if (s1_syn_q == '0) begin
            sb_d = 1'b1;
         end else if (int'(s1_syn_q) <= N) begin
            sb_d = 1'b1;
            flip = 1'b1;
         end else begin
            db_d = 1'b1;
         end
      end else if (s1_syn_q != '0) begin
         db_d = 1'b1;
      end
      for (int i = 1; i <= N; i++) begin
         if (flip && (M'(i) == s1_syn_q)) fixed[i] = ~fixed[i];
      end
      for (int k = 0; k < K; k++) begin
         q_d[k] = fixed[data_pos(k)];
      end
   end

   // Stage 2 register: decoded word, syndrome and flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_valid_q <= 1'b0;
         q_q       <= '0;
         syn_q     <= '0;
         sb_q      <= 1'b0;
         db_q      <= 1'b0;
      end else if (en) begin
         q_valid_q <= s1_valid_q;
         q_q       <= q_d;
         syn_q     <= s1_syn_q;
         sb_q      <= sb_d;
         db_q      <= db_d;
      end
   end

   assign q_o        = q_q;
   assign syndrome_o = syn_q;
   assign sb_err_o   = sb_q;
   assign sb_fix_o   = sb_q;
   assign db_err_o   = db_q;
   assign q_valid_o  = q_valid_q;

`ifdef HAMMING_ERR_CNT_EN
   logic             out_hs;
   logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

   assign out_hs = q_valid_q && q_ready_i;

   // Saturating counts of delivered words; a clear request takes priority.
   always_comb begin
      sb_cnt_d = sb_cnt_q;
      db_cnt_d = db_cnt_q;
      if (clr_cnt_i) begin
         sb_cnt_d = '0;
         db_cnt_d = '0;
      end else if (out_hs) begin
         if (sb_q && (sb_cnt_q != '1)) sb_cnt_d = sb_cnt_q + 1'b1;
         if (db_q && (db_cnt_q != '1)) db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sb_cnt_q <= '0;
         db_cnt_q <= '0;
      end else begin
         sb_cnt_q <= sb_cnt_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign sb_cnt_o = sb_cnt_q;
   assign db_cnt_o = db_cnt_q;
`else
   logic unused_clr;
   assign unused_clr = clr_cnt_i;
   assign sb_cnt_o   = '0;
   assign db_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_hamming_dec_stream.sv
// Testbench for hamming_dec_stream: directed vectors, stall, mid-stream
// reset, counter saturation/clear and a randomized stream against a
// scoreboard whose expectations come from the injected errors.
module tb_hamming_dec_stream;
   localparam int K     = 8;
   localparam int M     = 4;
   localparam int N     = 12;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [K-1:0] q;
      logic [M-1:0] syn;
      logic         sb;
      logic         db;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic [N:0]       cw_i = '0;
   logic             cw_valid_i = 1'b0;
   logic             cw_ready_o;
   logic [K-1:0]     q_o;
   logic [M-1:0]     syndrome_o;
   logic             sb_err_o, sb_fix_o, db_err_o, q_valid_o;
   logic             q_ready_i = 1'b0;
   logic             clr_cnt_i = 1'b0;
   logic [CNT_W-1:0] sb_cnt_o, db_cnt_o;

   int   checks = 0;
   int   failures = 0;
   int   sb_model = 0;
   int   db_model = 0;
   exp_t scb[$];

   always #5 clk = ~clk;

   hamming_dec_stream #(.K(K), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .cw_i(cw_i), .cw_valid_i(cw_valid_i),
      .cw_ready_o(cw_ready_o), .q_o(q_o), .syndrome_o(syndrome_o),
      .sb_err_o(sb_err_o), .sb_fix_o(sb_fix_o), .db_err_o(db_err_o),
      .q_valid_o(q_valid_o), .q_ready_i(q_ready_i), .clr_cnt_i(clr_cnt_i),
      .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o)
   );

   function automatic int cnt_exp(input int m);
`ifdef HAMMING_ERR_CNT_EN
      return m;
`else
      return 0;
`endif
   endfunction

   // Data bits go to non-power-of-two positions; parity bits at 2**i take
   // bit i of the XOR of data positions so the total syndrome is zero.
   function automatic logic [N:0] encode(input logic [K-1:0] d);
      logic [N:0] cw;
      int j, s;
      cw = '0; j = 0; s = 0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[j];
            if (d[j]) s = s ^ p;
            j++;
         end
      end
      for (int i = 0; i < M; i++) if (((s >> i) & 1) == 1) cw[1 << i] = 1'b1;
      cw[0] = ^cw[N:1];
      return cw;
   endfunction

   function automatic logic [K-1:0] extract(input logic [N:0] cw);
      logic [K-1:0] d;
      int j;
      d = '0; j = 0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[j] = cw[p];
            j++;
         end
      end
      return d;
   endfunction

   // Build a codeword with nerr (0..2) flips at distinct positions pa, pb.
   task automatic make(input logic [K-1:0] d, input int nerr, input int pa, input int pb,
                       output logic [N:0] cw, output exp_t e);
      cw = encode(d);
      if (nerr >= 1) cw[pa] = ~cw[pa];
      if (nerr >= 2) cw[pb] = ~cw[pb];
      if (nerr == 0)      e = '{q: d, syn: 4'd0, sb: 1'b0, db: 1'b0};
      else if (nerr == 1) e = '{q: d, syn: M'(pa), sb: 1'b1, db: 1'b0};
      else                e = '{q: extract(cw), syn: M'(pa ^ pb), sb: 1'b0, db: 1'b1};
   endtask

   // One clock cycle: drive at negedge, sample 1 ns later, update scoreboard.
   task automatic step(input logic v, input logic [N:0] cw, input logic rdy, input logic clr,
                       input exp_t e, output logic acc);
      exp_t f;
      @(negedge clk);
      cw_valid_i = v; cw_i = cw; q_ready_i = rdy; clr_cnt_i = clr;
      #1;
      checks++;
      if (cw_ready_o !== (!q_valid_o || rdy)) begin
         failures++;
         $display("FAIL cw_ready got=%b exp=%b", cw_ready_o, (!q_valid_o || rdy));
      end
      checks++;
      if (sb_cnt_o !== CNT_W'(cnt_exp(sb_model)) || db_cnt_o !== CNT_W'(cnt_exp(db_model))) begin
         failures++;
         $display("FAIL counters got sb=%0d db=%0d exp sb=%0d db=%0d",
                  sb_cnt_o, db_cnt_o, cnt_exp(sb_model), cnt_exp(db_model));
      end
      if (q_valid_o) begin
         checks++;
         if (scb.size() == 0) begin
            failures++;
            $display("FAIL output unexpected q=%h syn=%h", q_o, syndrome_o);
         end else begin
            f = scb[0];
            if (q_o !== f.q || syndrome_o !== f.syn || sb_err_o !== f.sb ||
                sb_fix_o !== f.sb || db_err_o !== f.db) begin
               failures++;
               $display("FAIL output got q=%h syn=%h sb=%b fix=%b db=%b exp q=%h syn=%h sb=%b db=%b",
                        q_o, syndrome_o, sb_err_o, sb_fix_o, db_err_o, f.q, f.syn, f.sb, f.db);
            end
            if (rdy) void'(scb.pop_front());
         end
      end
      if (clr) begin
         sb_model = 0; db_model = 0;
      end else if (q_valid_o && rdy && scb.size() >= 0) begin
         if (f.sb && sb_model < CMAX) sb_model++;
         if (f.db && db_model < CMAX) db_model++;
      end
      acc = v && cw_ready_o;
      if (acc) scb.push_back(e);
   endtask

   task automatic drain();
      logic a;
      for (int i = 0; i < 10 && (scb.size() != 0 || q_valid_o); i++) step(1'b0, '0, 1'b1, 1'b0, '0, a);
      checks++;
      if (scb.size() != 0 || q_valid_o) begin
         failures++;
         $display("FAIL drain pending=%0d valid=%b", scb.size(), q_valid_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      scb.delete(); sb_model = 0; db_model = 0;
      #1;
      checks++;
      if (q_o !== '0 || syndrome_o !== '0 || sb_err_o || sb_fix_o || db_err_o || q_valid_o ||
          sb_cnt_o !== '0 || db_cnt_o !== '0 || cw_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset q=%h syn=%h flags=%b%b%b v=%b cnt=%0d/%0d rdy=%b", q_o, syndrome_o,
                  sb_err_o, sb_fix_o, db_err_o, q_valid_o, sb_cnt_o, db_cnt_o, cw_ready_o);
      end
   endtask

   task automatic test_vectors();
      logic a;
      step(1'b1, 13'h144E, 1'b1, 1'b0, '{q: 8'hA5, syn: 4'd0, sb: 1'b0, db: 1'b0}, a);
      step(1'b0, '0, 1'b1, 1'b0, '0, a);
      checks++;
      if (q_valid_o !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", q_valid_o); end
      step(1'b1, 13'h140E, 1'b1, 1'b0, '{q: 8'hA5, syn: 4'd6, sb: 1'b1, db: 1'b0}, a);
      checks++;
      if (q_valid_o !== 1'b1) begin failures++; $display("FAIL latency_2 got=%b exp=1", q_valid_o); end
      step(1'b1, 13'h144F, 1'b1, 1'b0, '{q: 8'hA5, syn: 4'd0, sb: 1'b1, db: 1'b0}, a);
      step(1'b1, 13'h1466, 1'b1, 1'b0, '{q: 8'hA6, syn: 4'd6, sb: 1'b0, db: 1'b1}, a);
      // three flips at 1, 2, 12: syndrome 15 lies beyond N, data passed raw
      step(1'b1, encode(8'h3C) ^ 13'h1006, 1'b1, 1'b0,
           '{q: extract(encode(8'h3C) ^ 13'h1006), syn: 4'd15, sb: 1'b0, db: 1'b1}, a);
      drain();
   endtask

   task automatic test_back_to_back();
      logic [N:0] cws[4];
      exp_t       es[4];
      int         idx, cyc;
      logic       a;
      make(8'h11, 0, 0, 0, cws[0], es[0]);
      make(8'h22, 1, 7, 0, cws[1], es[1]);
      make(8'h33, 2, 3, 9, cws[2], es[2]);
      make(8'h44, 1, 0, 0, cws[3], es[3]);
      idx = 0;
      for (cyc = 0; cyc < 20 && idx < 4; cyc++) begin
         step(1'b1, cws[idx], !(cyc >= 2 && cyc <= 4), 1'b0, es[idx], a);
         if (cyc >= 2 && cyc <= 4) begin
            checks++;
            if (cw_ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", cw_ready_o); end
         end
         if (a) idx++;
      end
      checks++;
      if (idx != 4) begin failures++; $display("FAIL b2b_accepted got=%0d exp=4", idx); end
      drain();
   endtask

   task automatic test_reset_midstream();
      logic [N:0] cw;
      exp_t       e;
      logic       a;
      make(8'h5A, 0, 0, 0, cw, e);
      step(1'b1, cw, 1'b0, 1'b0, e, a);
      step(1'b1, cw ^ 13'h0010, 1'b0, 1'b0, '{q: 8'h5A, syn: 4'd4, sb: 1'b1, db: 1'b0}, a);
      @(negedge clk);
      rst_i = 1'b1; cw_valid_i = 1'b0; q_ready_i = 1'b1;
      scb.delete(); sb_model = 0; db_model = 0;
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      checks++;
      if (q_valid_o !== 1'b0 || sb_cnt_o !== '0 || db_cnt_o !== '0) begin
         failures++;
         $display("FAIL midreset valid=%b cnt=%0d/%0d exp 0", q_valid_o, sb_cnt_o, db_cnt_o);
      end
      repeat (3) step(1'b0, '0, 1'b1, 1'b0, '0, a);
   endtask

   task automatic test_counters();
      logic [N:0] cw;
      exp_t       e;
      logic       a;
      step(1'b0, '0, 1'b1, 1'b1, '0, a);
      for (int i = 0; i < 5; i++) begin
         make(K'(i * 37), 1, i + 1, 0, cw, e);
         step(1'b1, cw, 1'b1, 1'b0, e, a);
      end
      make(8'h99, 2, 2, 11, cw, e);
      step(1'b1, cw, 1'b1, 1'b0, e, a);
      drain();
      checks++;
      if (sb_cnt_o !== CNT_W'(cnt_exp(3)) || db_cnt_o !== CNT_W'(cnt_exp(1))) begin
         failures++;
         $display("FAIL saturate got sb=%0d db=%0d exp sb=%0d db=%0d", sb_cnt_o, db_cnt_o, cnt_exp(3), cnt_exp(1));
      end
      make(8'h77, 2, 0, 5, cw, e);
      step(1'b1, cw, 1'b1, 1'b0, e, a);
      step(1'b0, '0, 1'b1, 1'b0, '0, a);
      step(1'b0, '0, 1'b1, 1'b1, '0, a);
      step(1'b0, '0, 1'b1, 1'b0, '0, a);
      checks++;
      if (sb_cnt_o !== '0 || db_cnt_o !== '0) begin
         failures++;
         $display("FAIL clear_wins got sb=%0d db=%0d exp 0", sb_cnt_o, db_cnt_o);
      end
   endtask

   task automatic test_random();
      logic [N:0] cw;
      exp_t       e;
      logic       a;
      int         nerr, pa, pb;
      for (int i = 0; i < 400; i++) begin
         nerr = $urandom_range(0, 2);
         pa = $urandom_range(0, N);
         pb = $urandom_range(0, N);
         while (pb == pa) pb = $urandom_range(0, N);
         make(K'($urandom), nerr, pa, pb, cw, e);
         step($urandom_range(0, 3) != 0, cw, $urandom_range(0, 3) != 0,
              $urandom_range(0, 40) == 0, e, a);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_midstream();
      test_counters();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
